// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter_pkg: Avalon-MM request/response types and arbiter FSM states.
package cache_mem_arbiter_pkg;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [31:0] address;
        logic [31:0] writedata;
        logic [3:0]  byteenable;
    } avalon_req_t;

    typedef struct packed {
        logic [31:0] readdata;
        logic        readdatavalid;
        logic        waitrequest;
    } avalon_resp_t;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_e;

endpackage

// File: rtl/cache_mem_arbiter_rr.sv
// rr_arbiter: find-first-set over req, scanning upward from a rotating pointer.
module rr_arbiter #(
    parameter int N = 2,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant,
    output logic         valid
);

    logic [W-1:0] idx;

    // Walk offsets from farthest to nearest so the closest requester wins.
    always_comb begin
        grant = ptr;
        idx   = ptr;
        valid = |req;
        for (int i = N - 1; i >= 0; i--) begin
            idx = W'((int'(ptr) + i) % N);
            grant = req[idx] ? idx : grant;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin sharing of one Avalon-MM memory port between cache masters.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  avalon_req_t  [NUM_REQ-1:0] req_avn_req,
    output avalon_resp_t [NUM_REQ-1:0] req_avn_resp,
    output avalon_req_t                mem_avn_req,
    input  avalon_resp_t               mem_avn_resp
);

    localparam int W = $clog2(NUM_REQ);

    arb_state_e   state, state_nxt;
    logic [W-1:0] owner, owner_nxt, rr_ptr, rr_ptr_nxt, gnt, cur;
    logic [NUM_REQ-1:0] pending;
    logic         gnt_vld, act, rw, rd, accept, rdv;
    avalon_req_t  sel;

    function automatic logic [W-1:0] nxt_idx(input logic [W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        pending = '0;
        for (int i = 0; i < NUM_REQ; i++)
            pending[i] = req_avn_req[i].read | req_avn_req[i].write;
    end

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req   (pending),
        .ptr   (rr_ptr),
        .grant (gnt),
        .valid (gnt_vld)
    );

    // In IDLE the fresh grant drives memory in the same cycle, so IDLE+grant acts like BUSY.
    assign cur    = (state == IDLE) ? gnt : owner;
    assign sel    = req_avn_req[cur];
    assign act    = rst && (state == BUSY || (state == IDLE && gnt_vld));
    assign rw     = sel.read | sel.write;
    assign rd     = sel.read && !sel.write;
    assign accept = act && rw && !mem_avn_resp.waitrequest;
    assign rdv    = mem_avn_resp.readdatavalid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        if (act) begin
            owner_nxt = cur;
            if (!rw) begin
                state_nxt = IDLE;
            end else if (accept && (!rd || (state == BUSY && rdv))) begin
                state_nxt  = IDLE;
                rr_ptr_nxt = nxt_idx(cur);
            end else begin
                state_nxt = accept ? RESP : BUSY;
            end
        end else if (state == RESP && rdv) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = nxt_idx(owner);
        end
    end

    always_comb begin
        mem_avn_req       = sel;
        mem_avn_req.read  = act && rd;
        mem_avn_req.write = act && sel.write;
        req_avn_resp      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_avn_resp[i].readdata      = mem_avn_resp.readdata;
            req_avn_resp[i].waitrequest   = !(act && cur == W'(i)) || mem_avn_resp.waitrequest;
            req_avn_resp[i].readdatavalid = rdv && ((state == RESP && owner == W'(i)) ||
                                            (state == BUSY && accept && rd && cur == W'(i)));
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_chk
        assert property (@(posedge clk) disable iff (!rst)
            !(req_avn_req[g].read && req_avn_req[g].write));
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed scoreboard bench for the cache/memory arbiter.
module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    localparam int NUM_REQ = 2;

    typedef struct packed {
        logic        rsp;
        logic [1:0]  m;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    avalon_req_t  [NUM_REQ-1:0] req_avn_req;
    avalon_resp_t [NUM_REQ-1:0] req_avn_resp;
    avalon_req_t                mem_avn_req;
    avalon_resp_t               mem_avn_resp;
    avalon_req_t                mreq [NUM_REQ];

    int checks = 0, errors = 0;
    int mem_wait = 0, mem_lat = 1, wcnt = 0, cnt = 0;
    logic        rdv = 1'b0;
    logic [31:0] rdata = '0, pdata = '0;
    ev_t evq[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_drv
        assign req_avn_req[g] = mreq[g];
    end

    assign mem_avn_resp.waitrequest   = (mem_avn_req.read || mem_avn_req.write) && (wcnt < mem_wait);
    assign mem_avn_resp.readdatavalid = rdv;
    assign mem_avn_resp.readdata      = rdata;

    cache_mem_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_avn_req  (req_avn_req),
        .req_avn_resp (req_avn_resp),
        .mem_avn_req  (mem_avn_req),
        .mem_avn_resp (mem_avn_resp)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h req=%h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s act=timeout req=accept", name);
    endtask

    task automatic push_mem(input int m, input logic wr, input logic [31:0] a, input logic [31:0] d);
        evq.push_back({1'b0, 2'(m), wr, a, d});
    endtask

    task automatic push_rsp(input int m, input logic [31:0] d);
        evq.push_back({1'b1, 2'(m), 1'b0, 32'h0, d});
    endtask

    task automatic expect_ev(input string name, input ev_t got);
        ev_t e;
        checks++;
        if (evq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s act=%h req=none", name, got);
        end else begin
            checks--;
            e = evq.pop_front();
            chk(name, 80'(got), 80'(e));
        end
    endtask

    task automatic master_op(input int m, input bit wr, input logic [31:0] a, input logic [31:0] d);
        logic w;
        int n;
        mreq[m].read       = !wr;
        mreq[m].write      = wr;
        mreq[m].address    = a;
        mreq[m].writedata  = d;
        mreq[m].byteenable = 4'hF;
        n = 0;
        do begin
            @(negedge clk);
            w = req_avn_resp[m].waitrequest;
            @(posedge clk);
            n++;
        end while (w && n < 100);
        if (w) fail("accept_timeout");
        #1;
        mreq[m].read  = 1'b0;
        mreq[m].write = 1'b0;
    endtask

    // Memory model: waitrequest for mem_wait cycles per request, read data mem_lat cycles after accept.
    always @(posedge clk) begin
        rdv  <= 1'b0;
        wcnt <= mem_avn_resp.waitrequest ? wcnt + 1 : 0;
        if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                rdv   <= 1'b1;
                rdata <= pdata;
            end
        end
        if (rst && mem_avn_req.read && !mem_avn_resp.waitrequest) begin
            if (mem_lat <= 1) begin
                rdv   <= 1'b1;
                rdata <= mem_data(mem_avn_req.address);
            end else begin
                cnt   <= mem_lat - 1;
                pdata <= mem_data(mem_avn_req.address);
            end
        end
    end

    initial forever begin
        int om;
        @(negedge clk);
        for (int m = 0; m < NUM_REQ; m++)
            if (req_avn_resp[m].readdatavalid)
                expect_ev("rsp", {1'b1, 2'(m), 1'b0, 32'h0, req_avn_resp[m].readdata});
        if (rst && (mem_avn_req.read || mem_avn_req.write) && !mem_avn_resp.waitrequest) begin
            om = 3;
            for (int m = 0; m < NUM_REQ; m++)
                if (!req_avn_resp[m].waitrequest) om = m;
            expect_ev("mem", {1'b0, 2'(om), mem_avn_req.write, mem_avn_req.address, mem_avn_req.writedata});
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=running req=finished");
        $fatal(1);
    end

    initial begin
        int n;
        for (int m = 0; m < NUM_REQ; m++) mreq[m] = '0;
        repeat (2) @(negedge clk);
        chk("rst_iwait", req_avn_resp[0].waitrequest, 1);
        chk("rst_dwait", req_avn_resp[1].waitrequest, 1);
        chk("rst_mread", mem_avn_req.read, 0);
        chk("rst_mwrite", mem_avn_req.write, 0);
        chk("rst_rdv", {req_avn_resp[1].readdatavalid, req_avn_resp[0].readdatavalid}, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // icache single read
        push_mem(0, 0, 32'h100, 0);
        push_rsp(0, 32'hDEADBEEF);
        n = 0;
        fork
            master_op(0, 0, 32'h100, 0);
            begin
                repeat (4) begin
                    @(negedge clk);
                    if (mem_avn_req.read) n++;
                end
            end
        join
        chk("t1_read_cycles", n, 1);
        @(posedge clk); #1;

        // dcache write stalled three cycles
        mem_wait = 3;
        push_mem(1, 1, 32'h300, 32'hCAFEF00D);
        fork
            master_op(1, 1, 32'h300, 32'hCAFEF00D);
            begin
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    chk("t3_addr", mem_avn_req.address, 32'h300);
                    chk("t3_data", mem_avn_req.writedata, 32'hCAFEF00D);
                    chk("t3_write", mem_avn_req.write, 1);
                    chk("t3_dwait", req_avn_resp[1].waitrequest, 80'(c < 3));
                    chk("t3_iwait", req_avn_resp[0].waitrequest, 1);
                end
            end
        join
        mem_wait = 0;
        @(posedge clk); #1;

        // simultaneous icache read and dcache write
        push_mem(0, 0, 32'h100, 0);
        push_rsp(0, 32'hDEADBEEF);
        push_mem(1, 1, 32'h200, 32'h12345678);
        fork
            master_op(0, 0, 32'h100, 0);
            master_op(1, 1, 32'h200, 32'h12345678);
        join
        repeat (3) @(posedge clk); #1;

        // back-to-back reads from both masters alternate
        for (int i = 0; i < 4; i++) begin
            push_mem(0, 0, 32'h1000 + 32'(i * 4), 0);
            push_rsp(0, mem_data(32'h1000 + 32'(i * 4)));
            push_mem(1, 0, 32'h2000 + 32'(i * 4), 0);
            push_rsp(1, mem_data(32'h2000 + 32'(i * 4)));
        end
        fork
            begin
                for (int i = 0; i < 4; i++) master_op(0, 0, 32'h1000 + 32'(i * 4), 0);
            end
            begin
                for (int j = 0; j < 4; j++) master_op(1, 0, 32'h2000 + 32'(j * 4), 0);
            end
        join
        repeat (3) @(posedge clk); #1;

        // icache withdraws before accept, then dcache is served
        mem_wait = 100;
        mreq[0].read    = 1'b1;
        mreq[0].address = 32'h400;
        repeat (2) begin
            @(negedge clk);
            chk("t6_iwait", req_avn_resp[0].waitrequest, 1);
            chk("t6_dwait", req_avn_resp[1].waitrequest, 1);
        end
        @(posedge clk); #1;
        mreq[0].read = 1'b0;
        @(negedge clk);
        chk("t6_drop_read", mem_avn_req.read, 0);
        mem_wait = 0;
        @(posedge clk); #1;
        push_mem(1, 0, 32'h500, 0);
        push_rsp(1, mem_data(32'h500));
        master_op(1, 0, 32'h500, 0);
        repeat (3) @(posedge clk); #1;

        // reset while a read is outstanding
        mem_lat = 3;
        push_mem(0, 0, 32'h600, 0);
        master_op(0, 0, 32'h600, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_mread", mem_avn_req.read, 0);
        chk("t5_mwrite", mem_avn_req.write, 0);
        chk("t5_iwait", req_avn_resp[0].waitrequest, 1);
        chk("t5_dwait", req_avn_resp[1].waitrequest, 1);
        chk("t5_rdv", {req_avn_resp[1].readdatavalid, req_avn_resp[0].readdatavalid}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_late_rdv", {req_avn_resp[1].readdatavalid, req_avn_resp[0].readdatavalid}, 0);
        mem_lat = 1;
        repeat (2) @(posedge clk); #1;

        // normal service resumes after reset
        push_mem(0, 0, 32'h700, 0);
        push_rsp(0, mem_data(32'h700));
        master_op(0, 0, 32'h700, 0);
        repeat (3) @(posedge clk); #1;

        chk("evq_empty", evq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
